// File: rtl/mc_controller.sv
// Multicycle control unit for the ARM-subset datapath: instruction decode,
// per-instruction state sequencing, NZCV flag register and condition gating.
module mc_controller #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         EN_MUL      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        RegWrite2,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       regwrite;
    logic       regwrite2;
    logic       irwrite;
    logic       memwrite;
    logic       adrsrc;
    logic [1:0] regsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  state_t     state_reg, state_next;
  ctrl_t      ctrl_reg, ctrl_next, ctrl_out;
  logic [3:0] flags_reg;
  logic       condex_reg;

  logic [1:0] op;
  logic [3:0] cmd;
  logic       s_bit, mul_enc, is_mul, long_mul, is_cmp, dp_known, arith;
  logic       cond_now, cond_eff, writes;
  logic [2:0] alu_dec;
  logic       unused_instr;

  assign op       = Instr[27:26];
  assign cmd      = Instr[24:21];
  assign s_bit    = Instr[20];
  assign mul_enc  = (op == 2'b00) && !Instr[25] && (Instr[7:4] == 4'b1001);
  assign is_mul   = EN_MUL && mul_enc;
  assign long_mul = is_mul && Instr[23];
  assign is_cmp   = !mul_enc && (cmd == 4'b1010);
  assign arith    = !mul_enc && (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010);
  assign dp_known = arith || (!mul_enc && (cmd == 4'b0000 || cmd == 4'b1100));
  assign writes   = is_mul || (dp_known && !is_cmp);
  assign unused_instr = ^{Instr[19:8], Instr[3:0]};

  function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_met = z;
      4'b0001: cond_met = !z;
      4'b0010: cond_met = cf;
      4'b0011: cond_met = !cf;
      4'b0100: cond_met = n;
      4'b0101: cond_met = !n;
      4'b0110: cond_met = v;
      4'b0111: cond_met = !v;
      4'b1000: cond_met = cf && !z;
      4'b1001: cond_met = !cf || z;
      4'b1010: cond_met = (n == v);
      4'b1011: cond_met = (n != v);
      4'b1100: cond_met = !z && (n == v);
      4'b1101: cond_met = z || (n != v);
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  assign cond_now = cond_met(Instr[31:28], flags_reg);
  // The state leaving DECODE needs the condition before CondExR has latched it.
  assign cond_eff = (state_reg == DECODE) ? cond_now : condex_reg;

  always_comb begin
    alu_dec = 3'b000;
    if (is_mul) alu_dec = long_mul ? (Instr[22] ? 3'b110 : 3'b101) : 3'b100;
    else begin
      case (cmd)
        4'b0010, 4'b1010: alu_dec = 3'b001;
        4'b0000:          alu_dec = 3'b010;
        4'b1100:          alu_dec = 3'b011;
        default:          alu_dec = 3'b000;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!reset) state_next = FETCH;
    else begin
      case (state_reg)
        FETCH:   state_next = DECODE;
        DECODE: begin
          case (op)
            2'b01:   state_next = MEMADR;
            2'b10:   state_next = BRANCH;
            2'b00:   state_next = Instr[25] ? EXECI : EXECR;
            default: state_next = FETCH;
          endcase
        end
        MEMADR:  state_next = Instr[20] ? MEMREAD : MEMWRITE;
        MEMREAD: state_next = MEMWB;
        EXECR, EXECI: state_next = ALUWB;
        default: state_next = FETCH;
      endcase
    end
  end

  // Outputs are registered: compute the control word of the state being entered.
  always_comb begin
    ctrl_next = '0;
    case (state_next)
      FETCH: begin
        ctrl_next.irwrite = 1'b1;  ctrl_next.pcwrite = 1'b1;
        ctrl_next.alusrca = 2'b01; ctrl_next.alusrcb = 2'b10; ctrl_next.resultsrc = 2'b10;
      end
      DECODE: begin
        ctrl_next.alusrca = 2'b01; ctrl_next.alusrcb = 2'b10; ctrl_next.resultsrc = 2'b10;
      end
      MEMADR: begin
        ctrl_next.alusrcb = 2'b01; ctrl_next.immsrc = 2'b01; ctrl_next.regsrc = 2'b10;
      end
      MEMREAD:  ctrl_next.adrsrc = 1'b1;
      MEMWB: begin
        ctrl_next.resultsrc = 2'b01; ctrl_next.regwrite = cond_eff;
      end
      MEMWRITE: begin
        ctrl_next.adrsrc = 1'b1; ctrl_next.regsrc = 2'b10; ctrl_next.memwrite = cond_eff;
      end
      EXECR:    ctrl_next.alucontrol = alu_dec;
      EXECI: begin
        ctrl_next.alusrcb = 2'b01; ctrl_next.alucontrol = alu_dec;
      end
      ALUWB: begin
        ctrl_next.alucontrol = alu_dec;
        ctrl_next.regwrite   = cond_eff && writes;
        ctrl_next.regwrite2  = cond_eff && long_mul;
      end
      BRANCH: begin
        ctrl_next.regsrc = 2'b01; ctrl_next.alusrcb = 2'b01; ctrl_next.immsrc = 2'b10;
        ctrl_next.resultsrc = 2'b10; ctrl_next.pcwrite = cond_eff;
      end
      default: ctrl_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    state_reg <= state_next;
    ctrl_reg  <= ctrl_next;
    if (!reset) begin
      flags_reg  <= RESET_FLAGS;
      condex_reg <= 1'b0;
    end else begin
      if (state_reg == DECODE) condex_reg <= cond_now;
      if ((state_reg == EXECR || state_reg == EXECI) && condex_reg &&
          (dp_known || is_mul) && (s_bit || is_cmp)) begin
        flags_reg[3:2] <= ALUFlags[3:2];
        if (arith) flags_reg[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // While reset is held, enables are off and selects look like FETCH.
  always_comb begin
    ctrl_out = ctrl_reg;
    if (!reset) begin
      ctrl_out = '0;
      ctrl_out.alusrca   = 2'b01;
      ctrl_out.alusrcb   = 2'b10;
      ctrl_out.resultsrc = 2'b10;
    end
  end

  assign PCWrite    = ctrl_out.pcwrite;
  assign RegWrite   = ctrl_out.regwrite;
  assign RegWrite2  = ctrl_out.regwrite2;
  assign IRWrite    = ctrl_out.irwrite;
  assign MemWrite   = ctrl_out.memwrite;
  assign AdrSrc     = ctrl_out.adrsrc;
  assign RegSrc     = ctrl_out.regsrc;
  assign ALUSrcA    = ctrl_out.alusrca;
  assign ALUSrcB    = ctrl_out.alusrcb;
  assign ResultSrc  = ctrl_out.resultsrc;
  assign ImmSrc     = ctrl_out.immsrc;
  assign ALUControl = ctrl_out.alucontrol;
  assign State      = state_reg;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: runs hand-encoded instructions and checks
// the per-cycle state sequence and the gated enables against fixed expectations.
module tb_mc_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, RegWrite2, IRWrite, MemWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  int n_checks = 0;
  int n_errors = 0;

  logic [19:0] st_seq;
  logic [14:0] aluc_seq;
  logic [9:0]  rs_seq;
  logic [4:0]  rw_seq, rw2_seq, pcw_seq, mw_seq, irw_seq, adr_seq;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .RegWrite2(RegWrite2),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered during a FETCH cycle; records n cycles, then checks we are back in FETCH.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] fl,
                           input int n);
    Instr = ins;
    ALUFlags = fl;
    st_seq = '0; aluc_seq = '0; rs_seq = '0;
    rw_seq = '0; rw2_seq = '0; pcw_seq = '0; mw_seq = '0; irw_seq = '0; adr_seq = '0;
    #1;
    for (int k = 0; k < n; k++) begin
      st_seq   = {st_seq[15:0], State};
      aluc_seq = {aluc_seq[11:0], ALUControl};
      rs_seq   = {rs_seq[7:0], ResultSrc};
      rw_seq   = {rw_seq[3:0], RegWrite};
      rw2_seq  = {rw2_seq[3:0], RegWrite2};
      pcw_seq  = {pcw_seq[3:0], PCWrite};
      mw_seq   = {mw_seq[3:0], MemWrite};
      irw_seq  = {irw_seq[3:0], IRWrite};
      adr_seq  = {adr_seq[3:0], AdrSrc};
      next_cyc();
    end
    $display("instr %s %h: states %h regwrite %b pcwrite %b memwrite %b", tag, ins, st_seq,
             rw_seq, pcw_seq, mw_seq);
    check({tag, "_end_state"}, State, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    Instr = 32'h0;
    ALUFlags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", State, 32'd0);
    check("rst_enables", {PCWrite, RegWrite, RegWrite2, IRWrite, MemWrite}, 32'd0);
    check("rst_selects", {ALUSrcA, ALUSrcB, ResultSrc}, 32'b01_10_10);
    reset = 1'b1;
    #1;
    check("rel_state", State, 32'd0);
    check("rel_fetch_en", {IRWrite, PCWrite}, 32'b11);

    run_instr("add_imm", 32'hE2821005, 4'b0000, 4);
    check("add_states", st_seq, 32'h00178);
    check("add_regwrite", rw_seq, 32'b0001);
    check("add_irwrite", irw_seq, 32'b1000);
    check("add_pcwrite", pcw_seq, 32'b1000);
    check("add_aluctl", aluc_seq, 32'h000);

    run_instr("cmp_z", 32'hE3510000, 4'b0100, 4);
    check("cmp_regwrite", rw_seq, 32'b0000);
    check("cmp_aluctl", aluc_seq, 32'h009);
    run_instr("beq_taken", 32'h0A000002, 4'b0000, 3);
    check("beq_states", st_seq, 32'h019);
    check("beq_taken_pcw", pcw_seq, 32'b101);

    run_instr("cmp_nz", 32'hE3510000, 4'b0000, 4);
    run_instr("beq_not", 32'h0A000002, 4'b0100, 3);
    check("beq_not_pcw", pcw_seq, 32'b100);

    // ORRS must update N,Z but keep the C set by the preceding CMP.
    run_instr("cmp_c", 32'hE3510000, 4'b0010, 4);
    run_instr("orrs", 32'hE1911002, 4'b0100, 4);
    check("orrs_states", st_seq, 32'h0168);
    check("orrs_aluctl", aluc_seq, 32'h01B);
    check("orrs_regwrite", rw_seq, 32'b0001);
    run_instr("bcs", 32'h2A000000, 4'b0000, 3);
    check("bcs_c_held_pcw", pcw_seq, 32'b101);

    run_instr("ldr", 32'hE5910004, 4'b0000, 5);
    check("ldr_states", st_seq, 32'h01234);
    check("ldr_adrsrc", adr_seq, 32'b00010);
    check("ldr_regwrite", rw_seq, 32'b00001);
    check("ldr_resultsrc", rs_seq, 32'h281);

    run_instr("strne_z1", 32'h15810000, 4'b0000, 4);
    check("strne_states", st_seq, 32'h0125);
    check("strne_z1_memw", mw_seq, 32'b0000);
    run_instr("cmp_clr", 32'hE3510000, 4'b0000, 4);
    run_instr("strne_z0", 32'h15810000, 4'b0000, 4);
    check("strne_z0_memw", mw_seq, 32'b0001);
    check("strne_adrsrc", adr_seq, 32'b0001);

    run_instr("addeq_fail", 32'h02821005, 4'b0000, 4);
    check("addeq_states", st_seq, 32'h00178);
    check("addeq_regwrite", rw_seq, 32'b0000);

    run_instr("umull", 32'hE0821391, 4'b0000, 4);
    check("umull_states", st_seq, 32'h0168);
    check("umull_aluctl", aluc_seq, 32'h02D);
    check("umull_regwrite", rw_seq, 32'b0001);
    check("umull_regwrite2", rw2_seq, 32'b0001);
    run_instr("smull", 32'hE0C21391, 4'b0000, 4);
    check("smull_aluctl", aluc_seq, 32'h036);
    check("smull_regwrite2", rw2_seq, 32'b0001);

    // Reset asserted while a STR sits in MEMADR.
    Instr = 32'hE5810000;
    ALUFlags = 4'b0000;
    next_cyc();
    next_cyc();
    check("rstmid_memadr", State, 32'd2);
    reset = 1'b0;
    #1;
    check("rstmid_forced", {PCWrite, MemWrite, IRWrite}, 32'b000);
    next_cyc();
    check("rstmid_state", State, 32'd0);
    check("rstmid_memw", MemWrite, 32'd0);
    next_cyc();
    check("rstmid_hold_irw", IRWrite, 32'd0);
    reset = 1'b1;
    #1;
    check("rstmid_release", {IRWrite, PCWrite}, 32'b11);
    run_instr("post_rst_add", 32'hE2821005, 4'b0000, 4);
    check("post_rst_regwrite", rw_seq, 32'b0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
